// File: rtl/alu_result_buffer.sv
// Result/flags FIFO directly downstream of ALU_main, plus the architectural NZCV register.
// Optional sticky overflow tracking is compiled in with ALU_STICKY_OVF_EN.
module alu_result_buffer #(
   parameter int WIDTH = 4,
   parameter int DEPTH = 2
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       in_valid,
   output logic                       in_ready,
   input  logic [WIDTH-1:0]           in_result,
   input  logic [3:0]                 in_flags,
   input  logic                       set_flags,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic [WIDTH-1:0]           out_result,
   output logic [3:0]                 out_flags,
   output logic [3:0]                 flags_q,
`ifdef ALU_STICKY_OVF_EN
   output logic                       sticky_v,
   input  logic                       clr_sticky,
`endif
   output logic [$clog2(DEPTH):0]     count
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   typedef enum logic [1:0] {
      EMPTY   = 2'd0,
      PARTIAL = 2'd1,
      FULL    = 2'd2
   } state_t;

   state_t            state_q, state_d;
   logic [PW-1:0]     wr_ptr, rd_ptr;
   logic [CW-1:0]     count_q;
   logic [WIDTH-1:0]  res_mem [DEPTH];
   logic [3:0]        flg_mem [DEPTH];
   logic              push, pop;

   assign push = in_valid & in_ready;
   assign pop  = out_valid & out_ready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= EMPTY;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         EMPTY: begin
            if (push) state_d = PARTIAL;
         end
         PARTIAL: begin
            if (push && !pop && count_q == CW'(DEPTH - 1))
               state_d = FULL;
            else if (pop && !push && count_q == CW'(1))
               state_d = EMPTY;
         end
         FULL: begin
            if (pop) state_d = PARTIAL;
         end
         default: state_d = EMPTY;
      endcase
   end

   // Handshake depends only on occupancy, so in_ready never follows out_ready.
   always_comb begin
      in_ready  = (state_q != FULL);
      out_valid = (state_q != EMPTY);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         count_q <= '0;
         flags_q <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            res_mem[i] <= '0;
            flg_mem[i] <= '0;
         end
      end else begin
         if (push) begin
            res_mem[wr_ptr] <= in_result;
            flg_mem[wr_ptr] <= in_flags;
            wr_ptr          <= wr_ptr + PW'(1);
            if (set_flags) flags_q <= in_flags;
         end
         if (pop) rd_ptr <= rd_ptr + PW'(1);
         case ({push, pop})
            2'b10:   count_q <= count_q + CW'(1);
            2'b01:   count_q <= count_q - CW'(1);
            default: count_q <= count_q;
         endcase
      end
   end

   assign out_result = res_mem[rd_ptr];
   assign out_flags  = flg_mem[rd_ptr];
   assign count      = count_q;

`ifdef ALU_STICKY_OVF_EN
   // Set has priority so an overflow arriving with the clear is not lost.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sticky_v <= 1'b0;
      end else if (push && in_flags[0]) begin
         sticky_v <= 1'b1;
      end else if (clr_sticky) begin
         sticky_v <= 1'b0;
      end
   end
`endif

endmodule

// File: tb/tb_alu_result_buffer.sv
// Directed bench for alu_result_buffer (WIDTH=4, DEPTH=2); sticky checks build with ALU_STICKY_OVF_EN.
module tb_alu_result_buffer;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       in_valid;
   logic       in_ready;
   logic [3:0] in_result;
   logic [3:0] in_flags;
   logic       set_flags;
   logic       out_valid;
   logic       out_ready;
   logic [3:0] out_result;
   logic [3:0] out_flags;
   logic [3:0] flags_q;
   logic [1:0] count;
`ifdef ALU_STICKY_OVF_EN
   logic       sticky_v;
   logic       clr_sticky;
`endif

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   alu_result_buffer #(.WIDTH(4), .DEPTH(2)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_result  (in_result),
      .in_flags   (in_flags),
      .set_flags  (set_flags),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_result (out_result),
      .out_flags  (out_flags),
      .flags_q    (flags_q),
`ifdef ALU_STICKY_OVF_EN
      .sticky_v   (sticky_v),
      .clr_sticky (clr_sticky),
`endif
      .count      (count)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic v, input logic [3:0] r, input logic [3:0] f,
                        input logic sf, input logic ordy);
      in_valid  = v;
      in_result = r;
      in_flags  = f;
      set_flags = sf;
      out_ready = ordy;
   endtask

   initial begin
      rst_n = 1'b0;
`ifdef ALU_STICKY_OVF_EN
      clr_sticky = 1'b0;
`endif
      drive(1'b0, 4'h0, 4'h0, 1'b0, 1'b0);
      tick();
      tick();
      check("rst_count", 32'(count), 32'd0);
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_flags_q", 32'(flags_q), 32'd0);
      check("rst_out_result", 32'(out_result), 32'd0);
      #3 rst_n = 1'b1;
      tick();
      check("rst_in_ready", 32'(in_ready), 32'd1);

      // Single op: result 1100, flags 1010, set_flags=1
      drive(1'b1, 4'b1100, 4'b1010, 1'b1, 1'b0);
      #1 check("no_bypass", 32'(out_valid), 32'd0);
      tick();
      drive(1'b0, 4'h0, 4'h0, 1'b0, 1'b0);
      check("single_valid", 32'(out_valid), 32'd1);
      check("single_result", 32'(out_result), 32'b1100);
      check("single_flags", 32'(out_flags), 32'b1010);
      check("single_flags_q", 32'(flags_q), 32'b1010);
      check("single_count", 32'(count), 32'd1);
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      check("single_pop_count", 32'(count), 32'd0);
      check("single_pop_valid", 32'(out_valid), 32'd0);

      // Backpressure: fill with 0010, 1111
      drive(1'b1, 4'b0010, 4'b0000, 1'b0, 1'b0);
      tick();
      drive(1'b1, 4'b1111, 4'b1001, 1'b0, 1'b0);
      tick();
      check("full_count", 32'(count), 32'd2);
      check("full_in_ready", 32'(in_ready), 32'd0);
      check("full_head", 32'(out_result), 32'b0010);
      drive(1'b1, 4'b0101, 4'b0111, 1'b1, 1'b0);
      tick();
      check("full_ignore_count", 32'(count), 32'd2);
      check("full_ignore_flags_q", 32'(flags_q), 32'b1010);
      check("full_ignore_head", 32'(out_result), 32'b0010);
      // Pop while full with push offered: push must still be blocked
      out_ready = 1'b1;
      tick();
      in_valid = 1'b0;
      check("full_pop_count", 32'(count), 32'd1);
      check("pop_order_2nd", 32'(out_result), 32'b1111);
      check("pop_order_2nd_flags", 32'(out_flags), 32'b1001);
      tick();
      out_ready = 1'b0;
      check("drain_count", 32'(count), 32'd0);
      check("drain_valid", 32'(out_valid), 32'd0);

      // Simultaneous push and pop at count=1
      drive(1'b1, 4'b0011, 4'b0000, 1'b0, 1'b0);
      tick();
      check("sim_pre_head", 32'(out_result), 32'b0011);
      drive(1'b1, 4'b1000, 4'b1010, 1'b0, 1'b1);
      tick();
      check("sim_count", 32'(count), 32'd1);
      check("sim_head", 32'(out_result), 32'b1000);
      check("sim_head_flags", 32'(out_flags), 32'b1010);

      // set_flags=1 updates, set_flags=0 leaves flags_q alone
      drive(1'b1, 4'b0001, 4'b0100, 1'b1, 1'b0);
      tick();
      check("setf_flags_q", 32'(flags_q), 32'b0100);
      check("setf_count", 32'(count), 32'd2);
      drive(1'b0, 4'h0, 4'h0, 1'b0, 1'b1);
      tick();
      check("setf_head", 32'(out_result), 32'b0001);
      drive(1'b1, 4'b1111, 4'b1000, 1'b0, 1'b0);
      tick();
      drive(1'b0, 4'h0, 4'h0, 1'b0, 1'b0);
      check("nosetf_flags_q", 32'(flags_q), 32'b0100);
      check("nosetf_count", 32'(count), 32'd2);
      check("nosetf_head_flags", 32'(out_flags), 32'b0100);

      // Asynchronous reset mid-cycle with entries present
      #3 rst_n = 1'b0;
      #1;
      check("async_count", 32'(count), 32'd0);
      check("async_valid", 32'(out_valid), 32'd0);
      check("async_flags_q", 32'(flags_q), 32'd0);
      check("async_result", 32'(out_result), 32'd0);
      tick();
      #3 rst_n = 1'b1;
      tick();
      check("async_in_ready", 32'(in_ready), 32'd1);

`ifdef ALU_STICKY_OVF_EN
      check("sticky_rst", 32'(sticky_v), 32'd0);
      drive(1'b1, 4'b0000, 4'b0001, 1'b0, 1'b1);
      tick();
      check("sticky_set", 32'(sticky_v), 32'd1);
      drive(1'b1, 4'b0000, 4'b0000, 1'b0, 1'b1);
      tick();
      check("sticky_hold", 32'(sticky_v), 32'd1);
      in_valid   = 1'b0;
      clr_sticky = 1'b1;
      tick();
      check("sticky_clr", 32'(sticky_v), 32'd0);
      drive(1'b1, 4'b0000, 4'b0001, 1'b0, 1'b1);
      tick();
      clr_sticky = 1'b0;
      in_valid   = 1'b0;
      check("sticky_set_wins", 32'(sticky_v), 32'd1);
`endif

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
